// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and de-glitches the pins, frames 11-bit
// words and reduces make/break/E0 sequences to a held-key level plus pulses.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_key,
    output logic       o_ext,
    output logic       o_key_valid,
    output logic       o_frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic [FCW-1:0]         filt_cnt_r;
    logic                   filt_clk_r;
    logic                   filt_prev_r;
    logic [1:0]             state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   par_r;
    logic [TCW-1:0]         to_cnt_r;
    logic                   ext_pend_r;
    logic                   brk_pend_r;

    logic                   clk_synced_s;
    logic                   dat_synced_s;
    logic                   fall_s;
    logic                   frame_ok_s;
    logic                   timeout_s;

    // Decode edge, frame validity and timeout from registered state only.
    always_comb begin
        clk_synced_s = clk_sync_r[SYNC_STAGES-1];
        dat_synced_s = dat_sync_r[SYNC_STAGES-1];
        fall_s       = filt_prev_r & ~filt_clk_r;
        frame_ok_s   = dat_synced_s && odd_parity_ok(shift_r, par_r)
                       && (shift_r != 8'h00) && (shift_r != 8'hff);
        timeout_s    = (state_r != ST_IDLE) && !fall_s
                       && (to_cnt_r == TCW'(TIMEOUT_CYCLES - 1));
    end

    // Pin synchronisers and PS/2 clock glitch filter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            dat_sync_r  <= {SYNC_STAGES{1'b1}};
            filt_cnt_r  <= '0;
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], i_ps2_clk};
            dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], i_ps2_dat};
            filt_prev_r <= filt_clk_r;
            if (clk_synced_s == filt_clk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                filt_clk_r <= clk_synced_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end

    // Frame FSM, inter-edge timeout and scan-code interpretation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_r       <= 1'b0;
            to_cnt_r    <= '0;
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            o_key       <= 8'h00;
            o_ext       <= 1'b0;
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= 3'd0;
                        state_r   <= dat_synced_s ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        shift_r   <= {dat_synced_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        state_r   <= (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                    end
                    ST_PARITY: begin
                        par_r   <= dat_synced_s;
                        state_r <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        if (!frame_ok_s) begin
                            o_frame_err <= 1'b1;
                            ext_pend_r  <= 1'b0;
                            brk_pend_r  <= 1'b0;
                        end else if (shift_r == 8'he0) begin
                            ext_pend_r <= 1'b1;
                        end else if (shift_r == 8'hf0) begin
                            brk_pend_r <= 1'b1;
                        end else if (brk_pend_r) begin
                            // Only the release of the key currently shown clears it.
                            if ((shift_r == o_key) && (ext_pend_r == o_ext)) begin
                                o_key <= 8'h00;
                                o_ext <= 1'b0;
                            end else begin
                                o_key <= o_key;
                            end
                            ext_pend_r <= 1'b0;
                            brk_pend_r <= 1'b0;
                        end else begin
                            o_key       <= shift_r;
                            o_ext       <= ext_pend_r;
                            o_key_valid <= 1'b1;
                            ext_pend_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (state_r == ST_IDLE) begin
                to_cnt_r <= '0;
            end else if (timeout_s) begin
                state_r     <= ST_IDLE;
                to_cnt_r    <= '0;
                o_frame_err <= 1'b1;
                ext_pend_r  <= 1'b0;
                brk_pend_r  <= 1'b0;
            end else begin
                to_cnt_r <= to_cnt_r + TCW'(1);
            end
        end
    end

endmodule
